// File: rtl/lsu_pkg.sv
// Address map, lsu_op encodings and byte-lane helpers shared by the load-store unit.
package lsu_pkg;
    localparam logic [31:0] LEDR_ADDR   = 32'h0000_7000;
    localparam logic [31:0] LEDG_ADDR   = 32'h0000_7010;
    localparam logic [31:0] HEX_LO_ADDR = 32'h0000_7020;
    localparam logic [31:0] HEX_HI_ADDR = 32'h0000_7024;
    localparam logic [31:0] LCD_ADDR    = 32'h0000_7030;
    localparam logic [31:0] SW_ADDR     = 32'h0000_7800;
    localparam logic [31:0] BTN_ADDR    = 32'h0000_7810;
    localparam int          DMEM_BYTES  = 8192;

    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } lsu_op_e;

    function automatic logic op_valid(input logic [2:0] op);
        return (op == OP_B) || (op == OP_H) || (op == OP_W) ||
               (op == OP_BU) || (op == OP_HU);
    endfunction

    // Access size comes from op[1:0]; undefined encodings fall into the word class.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] a);
        if (!op_valid(op) || is_misaligned(op, a))
            return 4'b0000;
        case (op[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction
endpackage

// File: rtl/dmem.sv
// Word-wide data memory: byte-enabled synchronous write, asynchronous read.
module dmem #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-3:0] word_addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**(AW-2)];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[word_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[word_addr];
endmodule

// File: rtl/lsu.sv
// Load-store unit: combinational loads with extension, edge-committed stores, board I/O registers.
module lsu
    import lsu_pkg::*;
#(
    parameter int DMEM_AW = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic        st_en,
    input  logic [2:0]  lsu_op,
    input  logic [17:0] io_sw,
    input  logic [3:0]  io_btn,
    output logic [31:0] ld_data,
    output logic [16:0] io_ledr,
    output logic [7:0]  io_ledg,
    output logic [6:0]  io_hex0,
    output logic [6:0]  io_hex1,
    output logic [6:0]  io_hex2,
    output logic [6:0]  io_hex3,
    output logic [6:0]  io_hex4,
    output logic [6:0]  io_hex5,
    output logic [6:0]  io_hex6,
    output logic [6:0]  io_hex7,
    output logic [31:0] io_lcd,
    output logic        misaligned
);
    logic [16:0] ledr;
    logic [7:0]  ledg;
    logic [6:0]  hex [8];
    logic [31:0] lcd;
    logic [17:0] sw_q;
    logic [3:0]  btn_q;

    logic        in_dmem, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_lcd, sel_sw, sel_btn;
    logic        st_ok;
    logic [3:0]  be;
    logic [31:0] wdata, dmem_rd, rd_word, mask, merged;
    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        misaligned = is_misaligned(lsu_op, addr[1:0]);
        be         = byte_en(lsu_op, addr[1:0]);
        st_ok      = st_en && (be != 4'b0000);
        in_dmem    = (addr[31:DMEM_AW] == '0);
        sel_ledr   = addr[31:2] == LEDR_ADDR[31:2];
        sel_ledg   = addr[31:2] == LEDG_ADDR[31:2];
        sel_hex_lo = addr[31:2] == HEX_LO_ADDR[31:2];
        sel_hex_hi = addr[31:2] == HEX_HI_ADDR[31:2];
        sel_lcd    = addr[31:2] == LCD_ADDR[31:2];
        sel_sw     = addr[31:2] == SW_ADDR[31:2];
        sel_btn    = addr[31:2] == BTN_ADDR[31:2];

        case (lsu_op[1:0])
            2'b00:   wdata = {4{st_data[7:0]}};
            2'b01:   wdata = {2{st_data[15:0]}};
            default: wdata = st_data;
        endcase

        rd_word = '0;
        if (in_dmem)         rd_word = dmem_rd;
        else if (sel_ledr)   rd_word = {15'b0, ledr};
        else if (sel_ledg)   rd_word = {24'b0, ledg};
        else if (sel_hex_lo) rd_word = {1'b0, hex[3], 1'b0, hex[2], 1'b0, hex[1], 1'b0, hex[0]};
        else if (sel_hex_hi) rd_word = {1'b0, hex[7], 1'b0, hex[6], 1'b0, hex[5], 1'b0, hex[4]};
        else if (sel_lcd)    rd_word = lcd;
        else if (sel_sw)     rd_word = {14'b0, sw_q};
        else if (sel_btn)    rd_word = {28'b0, btn_q};

        // I/O registers take the current word with only the enabled lanes replaced.
        mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merged = (rd_word & ~mask) | (wdata & mask);

        lb = rd_word[{addr[1:0], 3'b000} +: 8];
        lh = addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (lsu_op)
            OP_B:    ld_data = {{24{lb[7]}}, lb};
            OP_H:    ld_data = {{16{lh[15]}}, lh};
            OP_W:    ld_data = rd_word;
            OP_BU:   ld_data = {24'b0, lb};
            OP_HU:   ld_data = {16'b0, lh};
            default: ld_data = '0;
        endcase
        if (misaligned)
            ld_data = '0;
    end

    dmem #(.AW(DMEM_AW)) u_dmem (
        .clk      (clk),
        .we       (st_ok && in_dmem && rst_n),
        .be       (be),
        .word_addr(addr[DMEM_AW-1:2]),
        .wdata    (wdata),
        .rdata    (dmem_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr  <= '0;
            ledg  <= '0;
            lcd   <= '0;
            sw_q  <= '0;
            btn_q <= '0;
            for (int i = 0; i < 8; i++)
                hex[i] <= '0;
        end else begin
            sw_q  <= io_sw;
            btn_q <= io_btn;
            if (st_ok) begin
                if (sel_ledr) ledr <= merged[16:0];
                if (sel_ledg) ledg <= merged[7:0];
                if (sel_lcd)  lcd  <= merged;
                if (sel_hex_lo) begin
                    hex[0] <= merged[6:0];
                    hex[1] <= merged[14:8];
                    hex[2] <= merged[22:16];
                    hex[3] <= merged[30:24];
                end
                if (sel_hex_hi) begin
                    hex[4] <= merged[6:0];
                    hex[5] <= merged[14:8];
                    hex[6] <= merged[22:16];
                    hex[7] <= merged[30:24];
                end
            end
        end
    end

    assign io_ledr = ledr;
    assign io_ledg = ledg;
    assign io_lcd  = lcd;
    assign io_hex0 = hex[0];
    assign io_hex1 = hex[1];
    assign io_hex2 = hex[2];
    assign io_hex3 = hex[3];
    assign io_hex4 = hex[4];
    assign io_hex5 = hex[5];
    assign io_hex6 = hex[6];
    assign io_hex7 = hex[7];
endmodule

// File: tb/tb_lsu.sv
// Directed vector bench for lsu: load extension, store lanes, I/O map, alignment and reset.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, st_data, ld_data, io_lcd;
    logic        st_en, misaligned;
    logic [2:0]  lsu_op;
    logic [17:0] io_sw;
    logic [3:0]  io_btn;
    logic [16:0] io_ledr;
    logic [7:0]  io_ledg;
    logic [6:0]  io_hex0, io_hex1, io_hex2, io_hex3, io_hex4, io_hex5, io_hex6, io_hex7;

    int n_chk  = 0;
    int n_fail = 0;

    lsu #(.DMEM_AW(13)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .st_data(st_data), .st_en(st_en),
        .lsu_op(lsu_op), .io_sw(io_sw), .io_btn(io_btn), .ld_data(ld_data),
        .io_ledr(io_ledr), .io_ledg(io_ledg),
        .io_hex0(io_hex0), .io_hex1(io_hex1), .io_hex2(io_hex2), .io_hex3(io_hex3),
        .io_hex4(io_hex4), .io_hex5(io_hex5), .io_hex6(io_hex6), .io_hex7(io_hex7),
        .io_lcd(io_lcd), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic [17:0] sw;
        logic [3:0]  btn;
        logic        chk;
        logic [31:0] exp_ld;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        st_en = s; lsu_op = op; addr = a; st_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, W, 32'h0, 32'h0);
        io_sw = '0; io_btn = '0;
        #3;
        check("reset_ledr", {15'b0, io_ledr}, 32'h0);
        check("reset_ledg", {24'b0, io_ledg}, 32'h0);
        check("reset_lcd",  io_lcd, 32'h0);
        check("reset_hex",  {4'b0, io_hex7, io_hex6, io_hex5, io_hex4}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //                st    op  addr          data          sw        btn  chk   exp_ld        mis
        vecs.push_back('{1'b1, W,  32'h100,  32'h8000_00FF, 18'h0,     4'h0, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, B,  32'h100,  32'h0,         18'h0,     4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, BU, 32'h103,  32'h0,         18'h0,     4'h0, 1'b1, 32'h0000_0080, 1'b0});
        vecs.push_back('{1'b0, H,  32'h102,  32'h0,         18'h0,     4'h0, 1'b1, 32'hFFFF_8000, 1'b0});
        vecs.push_back('{1'b0, HU, 32'h102,  32'h0,         18'h0,     4'h0, 1'b1, 32'h0000_8000, 1'b0});
        vecs.push_back('{1'b1, W,  32'h100,  32'h1122_3344, 18'h0,     4'h0, 1'b1, 32'h8000_00FF, 1'b0});
        vecs.push_back('{1'b1, B,  32'h101,  32'h0000_00AB, 18'h0,     4'h0, 1'b1, 32'h0000_0033, 1'b0});
        vecs.push_back('{1'b0, W,  32'h100,  32'h0,         18'h0,     4'h0, 1'b1, 32'h1122_AB44, 1'b0});
        vecs.push_back('{1'b0, H,  32'h101,  32'h0,         18'h0,     4'h0, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b1, W,  32'h102,  32'hDEAD_BEEF, 18'h0,     4'h0, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b1, H,  32'h103,  32'h0000_5555, 18'h0,     4'h0, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b0, W,  32'h100,  32'h0,         18'h0,     4'h0, 1'b1, 32'h1122_AB44, 1'b0});
        vecs.push_back('{1'b0, W,  32'h9000, 32'h0,         18'h0,     4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b1, W,  32'h7000, 32'hFFFF_FFFF, 18'h0,     4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, W,  32'h7000, 32'h0,         18'h0,     4'h0, 1'b1, 32'h0001_FFFF, 1'b0});
        vecs.push_back('{1'b0, H,  32'h7000, 32'h0,         18'h0,     4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b1, B,  32'h7025, 32'h0000_003F, 18'h0,     4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, W,  32'h7024, 32'h0,         18'h0,     4'h0, 1'b1, 32'h0000_3F00, 1'b0});
        vecs.push_back('{1'b1, B,  32'h7010, 32'h0000_005A, 18'h0,     4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b1, W,  32'h7030, 32'h0000_1234, 18'h0,     4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, BU, 32'h7010, 32'h0,         18'h0,     4'h0, 1'b1, 32'h0000_005A, 1'b0});
        vecs.push_back('{1'b0, W,  32'h7030, 32'h0,         18'h0,     4'h0, 1'b1, 32'h0000_1234, 1'b0});
        vecs.push_back('{1'b0, W,  32'h7800, 32'h0,         18'h2AAAA, 4'h0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, W,  32'h7800, 32'h0,         18'h2AAAA, 4'hF, 1'b1, 32'h0002_AAAA, 1'b0});
        vecs.push_back('{1'b1, W,  32'h7800, 32'hFFFF_FFFF, 18'h2AAAA, 4'hF, 1'b1, 32'h0002_AAAA, 1'b0});
        vecs.push_back('{1'b0, W,  32'h7800, 32'h0,         18'h2AAAA, 4'hF, 1'b1, 32'h0002_AAAA, 1'b0});
        vecs.push_back('{1'b0, W,  32'h7810, 32'h0,         18'h2AAAA, 4'hF, 1'b1, 32'h0000_000F, 1'b0});
        vecs.push_back('{1'b1, 3'b111, 32'h100, 32'h0,      18'h2AAAA, 4'hF, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h100, 32'h0,      18'h2AAAA, 4'hF, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 3'b110, 32'h102, 32'h0,      18'h2AAAA, 4'hF, 1'b1, 32'h0,         1'b1});
        vecs.push_back('{1'b0, W,  32'h100,  32'h0,         18'h2AAAA, 4'hF, 1'b1, 32'h1122_AB44, 1'b0});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].op, vecs[i].a, vecs[i].d);
            io_sw  = vecs[i].sw;
            io_btn = vecs[i].btn;
            #1;
            if (vecs[i].chk)
                check($sformatf("vec%0d_ld", i), ld_data, vecs[i].exp_ld);
            check($sformatf("vec%0d_mis", i), {31'b0, misaligned}, {31'b0, vecs[i].exp_mis});
        end

        @(negedge clk);
        drive(1'b0, W, 32'h9000, 32'h0);
        #1;
        check("out_ledr", {15'b0, io_ledr}, 32'h0001_FFFF);
        check("out_hex5", {25'b0, io_hex5}, 32'h3F);
        check("out_hex_others", {4'b0, io_hex7, io_hex6, 7'h0, io_hex4}, 32'h0);
        check("out_hex_lo", {4'b0, io_hex3, io_hex2, io_hex1, io_hex0}, 32'h0);
        check("out_ledg", {24'b0, io_ledg}, 32'h5A);
        check("out_lcd",  io_lcd, 32'h1234);

        // Reset asserted mid-cycle with a store pending across the next edge.
        @(negedge clk);
        drive(1'b1, W, 32'h100, 32'hCAFE_F00D);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ledg", {24'b0, io_ledg}, 32'h0);
        check("arst_lcd",  io_lcd, 32'h0);
        check("arst_ledr", {15'b0, io_ledr}, 32'h0);
        check("arst_hex5", {25'b0, io_hex5}, 32'h0);
        @(negedge clk);
        drive(1'b0, W, 32'h100, 32'h0);
        rst_n = 1'b1;
        #1;
        check("dmem_survives_reset", ld_data, 32'h1122_AB44);
        @(negedge clk);
        drive(1'b0, W, 32'h7800, 32'h0);
        #1;
        check("sw_sample_after_reset", ld_data, 32'h0002_AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
